// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
//   Shared constants for the iterative RV32M multiply/divide unit:
//   funct3 operation codes, FSM state encoding and the iteration-counter
//   width helper.
//   The divider datapath is built only when MULDIV_DIV_EN is defined.
// ----------------------------------------------------------------------------
package muldiv_pkg;

   // funct3 operation codes (RV32M, OP opcode with funct7 = 0000001)
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_CALC = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // Counter must hold 0..w-1
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int MULDIV_W_DEFAULT = 32;
   localparam int MULDIV_CNT_W     = cnt_width(MULDIV_W_DEFAULT);

endpackage

// File: rtl/muldiv_div_core.sv
// ----------------------------------------------------------------------------
// muldiv_div_core
//   One combinational restoring-divide step on unsigned magnitudes.
//   The partial remainder is shifted left taking in the next dividend bit
//   (the MSB of the quotient register); if the result is >= divisor it is
//   reduced and a 1 is shifted into the quotient, otherwise a 0.
//   Only instantiated when MULDIV_DIV_EN is defined.
// Ports
//   rem       in   W  current partial remainder (always < divisor)
//   quo       in   W  quotient register, dividend bits shift out of the MSB
//   divisor   in   W  divisor magnitude (non-zero)
//   rem_next  out  W  partial remainder after this step
//   quo_next  out  W  quotient register after this step
// ----------------------------------------------------------------------------
module muldiv_div_core
   import muldiv_pkg::*;
#(
   parameter int W = MULDIV_W_DEFAULT
)
(
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_next,
   output logic [W-1:0] quo_next
);

   logic [W:0]   shifted;
   logic [W-1:0] reduced;
   logic         ge;

   always_comb begin
      shifted = {rem, quo[W-1]};
      ge      = (shifted >= {1'b0, divisor});
      // When ge holds the true difference is < divisor, so the low W bits
      // of a modulo-2^W subtraction are exact.
      reduced = shifted[W-1:0] - divisor;
      rem_next = ge ? reduced : shifted[W-1:0];
      quo_next = {quo[W-2:0], ge};
   end

endmodule

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative radix-2 RV32M multiply/divide unit. Sits after the register
//   file read ports; its result/rd_out/we_out drive WD3/A3/WE3.
//   One product or quotient bit per cycle, start/busy/done handshake.
//   Build option: define MULDIV_DIV_EN to include DIV/DIVU/REM/REMU.
//   Without it, funct3[2]=1 completes one edge after start with result 0.
// Ports
//   CLK      in   1           clock, rising edge
//   rst      in   1           synchronous reset, active-high
//   start    in   1           request, sampled only while idle
//   funct3   in   3           operation select
//   rs1_val  in   DATA_WIDTH  operand A
//   rs2_val  in   DATA_WIDTH  operand B
//   rd_in    in   ADDR_WIDTH  destination register index
//   busy     out  1           operation in flight (through the done cycle)
//   done     out  1           one-cycle pulse, result valid
//   result   out  DATA_WIDTH  result, held until the next completion
//   rd_out   out  ADDR_WIDTH  latched destination index
//   we_out   out  1           register-file write enable (done, rd != 0)
// ----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
)
(
   input  logic                  CLK,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] rs1_val,
   input  logic [DATA_WIDTH-1:0] rs2_val,
   input  logic [ADDR_WIDTH-1:0] rd_in,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic [ADDR_WIDTH-1:0] rd_out,
   output logic                  we_out
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = cnt_width(W);
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   // State and datapath registers. hi/lo form the 2W shift register:
   // multiply: {partial product high, multiplier shifting out}
   // divide:   {partial remainder, dividend in / quotient out}
   logic [1:0]            state_reg;
   logic [CW-1:0]         cnt_reg;
   logic [2:0]            op_reg;
   logic                  sa_reg;
   logic                  sb_reg;
   logic [W-1:0]          opnd_reg;   // multiplicand or divisor magnitude
   logic [W-1:0]          hi_reg;
   logic [W-1:0]          lo_reg;
   logic [W-1:0]          result_reg;
   logic [ADDR_WIDTH-1:0] rd_reg;

   // ---------------- operand decode at start ----------------
   logic         a_signed_in, b_signed_in;
   logic         sa_in, sb_in;
   logic [W-1:0] a_mag_in, b_mag_in;
   logic         special;
   logic [W-1:0] special_result;

   always_comb begin
      a_signed_in = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                    (funct3 == OP_DIV)  || (funct3 == OP_REM);
      b_signed_in = (funct3 == OP_MULH) || (funct3 == OP_DIV) ||
                    (funct3 == OP_REM);
      sa_in    = a_signed_in && rs1_val[W-1];
      sb_in    = b_signed_in && rs2_val[W-1];
      // Most-negative value maps to itself, which is its correct unsigned
      // magnitude.
      a_mag_in = sa_in ? (~rs1_val + W'(1)) : rs1_val;
      b_mag_in = sb_in ? (~rs2_val + W'(1)) : rs2_val;
   end

`ifdef MULDIV_DIV_EN
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
   logic div_by_zero;
   logic div_ovf;

   always_comb begin
      div_by_zero = (rs2_val == '0);
      div_ovf     = b_signed_in && (rs1_val == MOST_NEG) && (rs2_val == '1);
      special     = funct3[2] && (div_by_zero || div_ovf);
      if (!funct3[1]) begin
         // quotient: /0 -> all ones, overflow -> dividend
         special_result = div_by_zero ? '1 : rs1_val;
      end else begin
         // remainder: /0 -> dividend, overflow -> 0
         special_result = div_by_zero ? rs1_val : '0;
      end
   end
`else
   always_comb begin
      special        = funct3[2];
      special_result = '0;
   end
`endif

   // ---------------- one iteration step ----------------
   logic [W:0]   mul_sum;
   logic [W-1:0] mul_hi_next, mul_lo_next;
   logic [W-1:0] step_hi, step_lo;

   always_comb begin
      mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
      mul_hi_next = mul_sum[W:1];
      mul_lo_next = {mul_sum[0], lo_reg[W-1:1]};
   end

`ifdef MULDIV_DIV_EN
   logic [W-1:0] div_rem_next, div_quo_next;

   muldiv_div_core #(.W(W)) u_div_core (
      .rem      (hi_reg),
      .quo      (lo_reg),
      .divisor  (opnd_reg),
      .rem_next (div_rem_next),
      .quo_next (div_quo_next)
   );

   always_comb begin
      step_hi = op_reg[2] ? div_rem_next : mul_hi_next;
      step_lo = op_reg[2] ? div_quo_next : mul_lo_next;
   end
`else
   always_comb begin
      step_hi = mul_hi_next;
      step_lo = mul_lo_next;
   end
`endif

   // ---------------- sign fix and final select ----------------
   // Evaluated on the last step so the corrected result is registered on
   // the same edge that enters DONE.
   logic [2*W-1:0] prod, prod_fix;
   logic [W-1:0]   mul_res, final_res;

   always_comb begin
      prod     = {step_hi, step_lo};
      prod_fix = (sa_reg ^ sb_reg) ? (~prod + (2*W)'(1)) : prod;
      mul_res  = (op_reg[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
   end

`ifdef MULDIV_DIV_EN
   logic [W-1:0] q_fix, r_fix;

   always_comb begin
      q_fix     = (sa_reg ^ sb_reg) ? (~step_lo + W'(1)) : step_lo;
      r_fix     = sa_reg ? (~step_hi + W'(1)) : step_hi;
      final_res = op_reg[2] ? (op_reg[1] ? r_fix : q_fix) : mul_res;
   end
`else
   always_comb begin
      final_res = op_reg[2] ? '0 : mul_res;
   end
`endif

   // ---------------- control FSM ----------------
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         op_reg     <= '0;
         sa_reg     <= 1'b0;
         sb_reg     <= 1'b0;
         opnd_reg   <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         result_reg <= '0;
         rd_reg     <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  op_reg <= funct3;
                  sa_reg <= sa_in;
                  sb_reg <= sb_in;
                  rd_reg <= rd_in;
                  if (special) begin
                     result_reg <= special_result;
                     state_reg  <= ST_DONE;
                  end else begin
                     cnt_reg   <= '0;
                     hi_reg    <= '0;
                     state_reg <= ST_CALC;
                     if (funct3[2]) begin
                        opnd_reg <= b_mag_in;
                        lo_reg   <= a_mag_in;
                     end else begin
                        opnd_reg <= a_mag_in;
                        lo_reg   <= b_mag_in;
                     end
                  end
               end
            end
            ST_CALC: begin
               hi_reg  <= step_hi;
               lo_reg  <= step_lo;
               cnt_reg <= cnt_reg + CW'(1);
               if (cnt_reg == LAST_CNT) begin
                  result_reg <= final_res;
                  state_reg  <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      busy   = (state_reg != ST_IDLE);
      done   = (state_reg == ST_DONE);
      we_out = done && (rd_reg != '0);
      result = result_reg;
      rd_out = rd_reg;
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit: a directed vector table, a few
//   hand-written multi-cycle sequences (ignored start, reset mid-operation)
//   and randomized operations checked against an arithmetic reference model.
//   Expectations follow MULDIV_DIV_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam int NORM_LAT = 33;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_val, rs2_val;
   logic [4:0]  rd_in;
   logic        busy, done, we_out;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .CLK     (clk),
      .rst     (rst),
      .start   (start),
      .funct3  (funct3),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .rd_in   (rd_in),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .rd_out  (rd_out),
      .we_out  (we_out)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp_res;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   // Reference model: RV32M semantics from plain 64-bit / signed arithmetic.
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      logic [31:0] r;
      logic        ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r = '0;
      case (f3)
         3'b000: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
         3'b001: begin ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; p = ea * eb; r = p[63:32]; end
         3'b010: begin ea = {{32{a[31]}}, a}; eb = {32'b0, b}; p = ea * eb; r = p[63:32]; end
         3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         3'b100: if (!DIV_EN) r = '0; else if (b == 0) r = '1; else if (ovf) r = a;
                 else r = $signed(a) / $signed(b);
         3'b101: if (!DIV_EN) r = '0; else if (b == 0) r = '1; else r = a / b;
         3'b110: if (!DIV_EN) r = '0; else if (b == 0) r = a; else if (ovf) r = '0;
                 else r = $signed(a) % $signed(b);
         default: if (!DIV_EN) r = '0; else if (b == 0) r = a; else r = a % b;
      endcase
      return r;
   endfunction

   function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return NORM_LAT;
      if (!DIV_EN || b == 0) return 1;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return NORM_LAT;
   endfunction

   // Issue one operation, wait for done (bounded), check everything.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
      int n;
      logic [31:0] got;
      @(negedge clk);
      funct3 = f3; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      while (!done && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      got = result;
      check({tag, " latency"}, 64'(n), 64'(exp_lat));
      check({tag, " result"}, {32'b0, got}, {32'b0, exp_res});
      check({tag, " rd_out"}, {59'b0, rd_out}, {59'b0, rd});
      check({tag, " we_out"}, {63'b0, we_out}, {63'b0, (rd != 0)});
      check({tag, " busy_in_done"}, {63'b0, busy}, 64'd1);
      $display("op %s f3=%b a=%h b=%h rd=%0d -> result=%h latency=%0d", tag, f3, a, b, rd, got, n);
      @(posedge clk); #1;
      check({tag, " done_pulse"}, {63'b0, done}, 64'd0);
      check({tag, " busy_clear"}, {63'b0, busy}, 64'd0);
      check({tag, " result_held"}, {32'b0, result}, {32'b0, exp_res});
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      vec_t vecs[13];
      int   n;
      logic saw_we;
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;

      vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, NORM_LAT};
      vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, NORM_LAT};
      vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, NORM_LAT};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF, NORM_LAT};
      vecs[4]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, NORM_LAT};
      vecs[5]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd6,  DIV_EN ? 32'hFFFF_FFFD : 32'h0, DIV_EN ? NORM_LAT : 1};
      vecs[6]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd7,  DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN ? NORM_LAT : 1};
      vecs[7]  = '{3'b101, 32'h0000_2004, 32'd6,         5'd8,  DIV_EN ? 32'h0000_0556 : 32'h0, DIV_EN ? NORM_LAT : 1};
      vecs[8]  = '{3'b100, 32'd5,         32'd0,         5'd9,  DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1};
      vecs[9]  = '{3'b110, 32'd5,         32'd0,         5'd10, DIV_EN ? 32'd5 : 32'h0, 1};
      vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, DIV_EN ? 32'h8000_0000 : 32'h0, 1};
      vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 1};
      vecs[12] = '{3'b000, 32'd2,         32'd3,         5'd0,  32'd6, NORM_LAT};

      rst = 1'b1; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy",   {63'b0, busy},   64'd0);
      check("reset done",   {63'b0, done},   64'd0);
      check("reset we_out", {63'b0, we_out}, 64'd0);
      check("reset result", {32'b0, result}, 64'd0);
      check("reset rd_out", {59'b0, rd_out}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
                vecs[i].exp_res, vecs[i].exp_lat);

      // Start pulses mid-calculation and in the done cycle are ignored.
      run_op("pre_ign", 3'b000, 32'd2, 32'd3, 5'd0, 32'd6, NORM_LAT);
      @(negedge clk);
      funct3 = 3'b000; rs1_val = 32'd4; rs2_val = 32'd5; rd_in = 5'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      repeat (10) begin @(posedge clk); #1; n++; end
      funct3 = 3'b101; rs1_val = 32'd100; rs2_val = 32'd0; rd_in = 5'd1; start = 1'b1;
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      check("ign busy",        {63'b0, busy},   64'd1);
      check("ign done",        {63'b0, done},   64'd0);
      check("ign result_held", {32'b0, result}, 64'd6);
      while (!done && n < 200) begin @(posedge clk); #1; n++; end
      check("ign latency", 64'(n), 64'(NORM_LAT));
      check("ign result",  {32'b0, result}, 64'd20);
      check("ign rd_out",  {59'b0, rd_out}, 64'd9);
      $display("op ign MUL 4x5 with mid-calc start -> result=%h latency=%0d", result, n);
      funct3 = 3'b000; rs1_val = 32'd1; rs2_val = 32'd1; rd_in = 5'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_start busy",   {63'b0, busy},   64'd0);
      check("done_start result", {32'b0, result}, 64'd20);

      // Reset at iteration 10 aborts with no write.
      @(negedge clk);
      funct3 = 3'b011; rs1_val = 32'h1234_5678; rs2_val = 32'h9ABC_DEF0; rd_in = 5'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid busy",   {63'b0, busy},   64'd0);
      check("rst_mid done",   {63'b0, done},   64'd0);
      check("rst_mid result", {32'b0, result}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_we = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (we_out || done) saw_we = 1'b1;
      end
      check("rst_mid no_write", {63'b0, saw_we}, 64'd0);
      $display("op rst_mid MULHU aborted at iteration 10");

      // Randomized operations against the reference model.
      for (int k = 0; k < 40; k++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         rd = 5'($urandom_range(0, 31));
         run_op($sformatf("rnd%0d", k), f3, a, b, rd, model(f3, a, b), model_lat(f3, a, b));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
